cache_ctrl: RTL and testbench



---
 rtl/cache_ctrl.sv | 173 +++++++++++++++++
 tb/tb_cache_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// Single-level cache controller FSM between the CPU request port and ACE.
// Outputs are registered: each output flop loads the decode of the state
// the FSM is about to enter, so outputs line up with the current state
// while coming straight from flops.
module cache_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       cache_hit,
  input  logic       cache_miss,
  input  logic [2:0] line_state,
  input  logic [1:0] cpu_request,
  input  logic       ace_ready,
  output logic       read_req,
  output logic       write_req,
  output logic       invalid_req,
  output logic       write_from_cpu,
  output logic       write_from_interconnect,
  output logic [2:0] new_state,
  output logic       state_sel,
  output logic       cache_complete,
  output logic       cache_ready
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_COMPARE    = 3'd1,
    S_WRITE_BACK = 3'd2,
    S_ALLOCATE   = 3'd3,
    S_FILL       = 3'd4,
    S_INVALIDATE = 3'd5,
    S_WRITE      = 3'd6,
    S_DONE       = 3'd7
  } state_e;

  typedef struct packed {
    logic       read_req;
    logic       write_req;
    logic       invalid_req;
    logic       write_from_cpu;
    logic       write_from_interconnect;
    logic [2:0] new_state;
    logic       state_sel;
    logic       cache_complete;
    logic       cache_ready;
  } ctrl_out_t;

  localparam logic [2:0] LS_I  = 3'b000;
  localparam logic [2:0] LS_UD = 3'b001;
  localparam logic [2:0] LS_UC = 3'b010;
  localparam logic [2:0] LS_SD = 3'b011;
  localparam logic [2:0] LS_SC = 3'b100;

  // Encodings above SC carry no meaning and are folded onto Invalid.
  function automatic logic [2:0] norm_state(input logic [2:0] ls);
    return (ls > LS_SC) ? LS_I : ls;
  endfunction

  // Moore output decode for a given state and latched victim state.
  function automatic ctrl_out_t decode(input state_e s, input logic [2:0] victim);
    ctrl_out_t o;
    o = '0;
    case (s)
      S_IDLE:       o.cache_ready = 1'b1;
      S_COMPARE:    o = '0;
      S_WRITE_BACK: begin
        o.write_req = 1'b1;
        o.state_sel = 1'b1;
        o.new_state = (victim == LS_SD) ? LS_SD : LS_I;
      end
      S_ALLOCATE:   o.read_req = 1'b1;
      S_FILL: begin
        o.write_from_interconnect = 1'b1;
        o.new_state               = LS_UC;
      end
      S_INVALIDATE: o.invalid_req = 1'b1;
      S_WRITE: begin
        o.write_from_cpu = 1'b1;
        o.new_state      = LS_UD;
      end
      S_DONE: begin
        o.cache_complete = 1'b1;
        o.cache_ready    = 1'b1;
      end
      default:      o.cache_ready = 1'b1;
    endcase
    return o;
  endfunction

  state_e     state_q, state_d;
  logic       is_write_q, is_write_d;
  logic [2:0] victim_q, victim_d;
  ctrl_out_t  out_q, out_d;
  logic [2:0] ls_norm_s;
  logic       lookup_miss_s;

  assign ls_norm_s     = norm_state(line_state);
  // A lookup with neither hit nor miss raised still counts as a miss.
  assign lookup_miss_s = cache_miss | ~cache_hit;

  // Next-state, request/victim latching and output decode.
  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    victim_d   = victim_q;
    case (state_q)
      S_IDLE: begin
        if ((cpu_request == 2'b00) || (cpu_request == 2'b01)) begin
          state_d    = S_COMPARE;
          is_write_d = cpu_request[0];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COMPARE: begin
        victim_d = ls_norm_s;
        if (cache_hit) begin
          if (!is_write_q) begin
            state_d = S_DONE;
          end else if ((ls_norm_s == LS_UD) || (ls_norm_s == LS_UC) || (ls_norm_s == LS_SD)) begin
            state_d = S_WRITE;
          end else if (ls_norm_s == LS_SC) begin
            state_d = S_INVALIDATE;
          end else begin
            // Hit on an Invalid line cannot supply data: refetch it.
            state_d = S_ALLOCATE;
          end
        end else if (lookup_miss_s) begin
          if ((ls_norm_s == LS_UD) || (ls_norm_s == LS_SD)) begin
            state_d = S_WRITE_BACK;
          end else begin
            state_d = S_ALLOCATE;
          end
        end else begin
          state_d = S_ALLOCATE;
        end
      end
      S_WRITE_BACK: state_d = ace_ready ? S_ALLOCATE : S_WRITE_BACK;
      S_ALLOCATE:   state_d = ace_ready ? S_FILL : S_ALLOCATE;
      S_FILL:       state_d = is_write_q ? S_WRITE : S_DONE;
      S_INVALIDATE: state_d = ace_ready ? S_WRITE : S_INVALIDATE;
      S_WRITE:      state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
    out_d = decode(state_d, victim_d);
  end

  // State, latched request context and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      is_write_q <= 1'b0;
      victim_q   <= LS_I;
      out_q      <= decode(S_IDLE, LS_I);
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      victim_q   <= victim_d;
      out_q      <= out_d;
    end
  end

  assign read_req                = out_q.read_req;
  assign write_req               = out_q.write_req;
  assign invalid_req             = out_q.invalid_req;
  assign write_from_cpu          = out_q.write_from_cpu;
  assign write_from_interconnect = out_q.write_from_interconnect;
  assign new_state               = out_q.new_state;
  assign state_sel               = out_q.state_sel;
  assign cache_complete          = out_q.cache_complete;
  assign cache_ready             = out_q.cache_ready;

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: a transaction-level model predicts the
// per-cycle output vector sequence of each request; randomized requests,
// lookup results and ACE handshake delays are checked against it.
module tb_cache_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cache_hit, cache_miss, ace_ready;
  logic [2:0] line_state;
  logic [1:0] cpu_request;
  logic       read_req, write_req, invalid_req, write_from_cpu, write_from_interconnect;
  logic [2:0] new_state;
  logic       state_sel, cache_complete, cache_ready;

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];
  bit          ace_q[$];
  logic [10:0] obs;

  cache_ctrl dut (
    .clk(clk), .reset(reset), .cache_hit(cache_hit), .cache_miss(cache_miss),
    .line_state(line_state), .cpu_request(cpu_request), .ace_ready(ace_ready),
    .read_req(read_req), .write_req(write_req), .invalid_req(invalid_req),
    .write_from_cpu(write_from_cpu), .write_from_interconnect(write_from_interconnect),
    .new_state(new_state), .state_sel(state_sel), .cache_complete(cache_complete),
    .cache_ready(cache_ready)
  );

  always #5 clk = ~clk;

  assign obs = {read_req, write_req, invalid_req, write_from_cpu, write_from_interconnect,
                new_state, state_sel, cache_complete, cache_ready};

  function automatic logic [10:0] mk(input logic rr, input logic wr, input logic ir,
                                     input logic wc, input logic wi, input logic [2:0] ns,
                                     input logic ss, input logic cc, input logic cr);
    return {rr, wr, ir, wc, wi, ns, ss, cc, cr};
  endfunction

  logic [10:0] v_idle, v_cmp, v_done, v_wr, v_fill, v_alloc, v_inv;

  task automatic check_eq(input string tag, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b (rr wr ir wc wi ns[3] ss cc cr)", tag, got, exp);
    end
  endtask

  task automatic push_any(input logic [10:0] v);
    exp_q.push_back(v);
    ace_q.push_back(1'($urandom_range(0, 1)));
  endtask

  // An ACE handshake: request held for dly cycles with ace_ready low, then one accepted cycle.
  task automatic add_phase(input logic [10:0] v, input int dly);
    for (int k = 0; k < dly; k++) begin
      exp_q.push_back(v);
      ace_q.push_back(1'b0);
    end
    exp_q.push_back(v);
    ace_q.push_back(1'b1);
  endtask

  // Reference model: expected outputs for each cycle after the request is taken in IDLE.
  task automatic build(input logic [1:0] req, input logic hit, input logic [2:0] ls, input int dly);
    int lsn;
    exp_q.delete();
    ace_q.delete();
    lsn = (ls > 3'd4) ? 0 : int'(ls);
    push_any(v_cmp);
    if (hit) begin
      if (req == 2'b00) begin
        push_any(v_done);
      end else if (lsn == 4) begin
        add_phase(v_inv, dly);
        push_any(v_wr);
        push_any(v_done);
      end else begin
        push_any(v_wr);
        push_any(v_done);
      end
    end else begin
      if (lsn == 1 || lsn == 3)
        add_phase(mk(0, 1, 0, 0, 0, (lsn == 3) ? 3'b011 : 3'b000, 1, 0, 0), dly);
      add_phase(v_alloc, dly);
      push_any(v_fill);
      if (req == 2'b01) push_any(v_wr);
      push_any(v_done);
    end
  endtask

  task automatic run_txn(input int id, input logic [1:0] req, input logic hit, input logic miss,
                         input logic [2:0] ls, input int dly);
    build(req, hit, ls, dly);
    @(negedge clk);
    check_eq($sformatf("t%0d_idle", id), obs, v_idle);
    cpu_request = req;
    cache_hit   = hit;
    cache_miss  = miss;
    line_state  = ls;
    ace_ready   = 1'($urandom_range(0, 1));
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check_eq($sformatf("t%0d_c%0d", id, i + 1), obs, exp_q[i]);
      if (i == 0) begin
        cpu_request = 2'b11;
      end else begin
        cpu_request = 2'($urandom);
        cache_hit   = 1'($urandom);
        cache_miss  = 1'($urandom);
        line_state  = 3'($urandom);
      end
      ace_ready = ace_q[i];
    end
  endtask

  initial begin
    logic [1:0] rq;
    logic       h, m;
    logic [2:0] ls;
    v_idle  = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 1);
    v_cmp   = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    v_done  = mk(0, 0, 0, 0, 0, 3'b000, 0, 1, 1);
    v_wr    = mk(0, 0, 0, 1, 0, 3'b001, 0, 0, 0);
    v_fill  = mk(0, 0, 0, 0, 1, 3'b010, 0, 0, 0);
    v_alloc = mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    v_inv   = mk(0, 0, 1, 0, 0, 3'b000, 0, 0, 0);

    reset = 1'b1;
    cpu_request = 2'b11;
    cache_hit = 1'b0; cache_miss = 1'b0; line_state = 3'b000; ace_ready = 1'b0;
    #1;
    check_eq("reset_state", obs, v_idle);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases.
    run_txn(1, 2'b00, 1'b1, 1'b0, 3'b010, 0);   // read hit
    run_txn(2, 2'b01, 1'b1, 1'b0, 3'b010, 0);   // write hit
    run_txn(3, 2'b00, 1'b0, 1'b1, 3'b011, 3);   // dirty victim, slow ACE
    run_txn(4, 2'b01, 1'b1, 1'b0, 3'b100, 0);   // write hit on shared clean
    run_txn(5, 2'b00, 1'b0, 1'b1, 3'b001, 1);   // unique dirty victim
    run_txn(6, 2'b00, 1'b0, 1'b1, 3'b000, 0);   // clean miss
    run_txn(7, 2'b00, 1'b1, 1'b1, 3'b010, 0);   // hit and miss both high
    run_txn(8, 2'b00, 1'b0, 1'b0, 3'b001, 0);   // neither high
    run_txn(9, 2'b01, 1'b0, 1'b1, 3'b110, 2);   // out-of-range state as I

    // Reset in the middle of ALLOCATE.
    @(negedge clk);
    check_eq("rst_pre_idle", obs, v_idle);
    cpu_request = 2'b00; cache_hit = 1'b0; cache_miss = 1'b1; line_state = 3'b000; ace_ready = 1'b0;
    @(negedge clk);
    check_eq("rst_cmp", obs, v_cmp);
    cpu_request = 2'b11;
    @(negedge clk);
    check_eq("rst_alloc", obs, v_alloc);
    #2 reset = 1'b1;
    #1 check_eq("rst_async", obs, v_idle);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cpu_request = (k % 2 == 0) ? 2'b11 : 2'b10;
      ace_ready = 1'($urandom);
      @(negedge clk);
      check_eq($sformatf("post_rst_idle%0d", k), obs, v_idle);
    end
    cpu_request = 2'b11;

    // Randomized traffic.
    for (int t = 0; t < 250; t++) begin
      rq = 2'($urandom_range(0, 1));
      h  = 1'($urandom);
      m  = 1'($urandom);
      ls = 3'($urandom);
      if (h && rq == 2'b01 && (ls == 3'b000 || ls > 3'b100)) ls = 3'($urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        check_eq($sformatf("gap%0d", t), obs, v_idle);
        cpu_request = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
      end
      run_txn(100 + t, rq, h, m, ls, $urandom_range(0, 3));
    end

    @(negedge clk);
    check_eq("final_idle", obs, v_idle);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
